uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_tx_core.sv | 136 +++++++++++++
 tb/tb_uart_tx_core.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: frame FSM states and baud divisor helper
package uart_pkg;

    // Frame sequencer states shared by the transmit and receive cores
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per line bit, truncated
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period tick generator, one tick every DIV enabled cycles
module uart_baud_gen #(
    parameter int DIV = 434
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int              LP_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(DIV - 1);

    logic [LP_W-1:0] r_cnt;

    // Count enabled cycles; held at zero while disabled so each enable starts a fresh period
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en || (r_cnt == LP_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter core; optional parity bit via UART_TX_PARITY_EN
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int P_CLK_FREQ   = 50_000_000,
    parameter int P_BAUD       = 115200,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_STOP_BITS  = 1,
    parameter int P_PARITY_ODD = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_DATA_WIDTH-1:0] i_tx_data,
    input  logic                    i_tx_valid,
    output logic                    o_tx_ready,
    output logic                    o_uart_tx
);

    localparam int       LP_DIV       = calc_div(P_CLK_FREQ, P_BAUD);
    localparam logic [2:0] LP_LAST_BIT = 3'(P_DATA_WIDTH - 1);
    localparam logic     LP_LAST_STOP = 1'(P_STOP_BITS - 1);
    // An illegal parameter set never raises ready, so no malformed frame can go out
    localparam logic     LP_CFG_OK    = (P_DATA_WIDTH >= 5) && (P_DATA_WIDTH <= 8) &&
                                        (P_STOP_BITS >= 1) && (P_STOP_BITS <= 2) &&
                                        (P_PARITY_ODD >= 0) && (P_PARITY_ODD <= 1) &&
                                        (LP_DIV >= 1);

    uart_state_t             r_state;
    logic [P_DATA_WIDTH-1:0] r_shift;
    logic [2:0]              r_bit_cnt;
    logic                    r_stop_cnt;
    logic                    r_tx;
    logic                    r_ready;
`ifdef UART_TX_PARITY_EN
    localparam logic         LP_ODD_BIT   = 1'(P_PARITY_ODD);
    logic                    r_parity;
`endif

    logic w_tick;
    logic w_baud_en;

    assign w_baud_en = (r_state != IDLE);

    uart_baud_gen #(
        .DIV (LP_DIV)
    ) u_baud_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_baud_en),
        .o_tick (w_tick)
    );

    // Frame sequencer: every output is registered so the line never glitches
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx    <= 1'b1;
                    r_ready <= LP_CFG_OK;
                    if (i_tx_valid && r_ready) begin
                        r_shift <= i_tx_data;
                        r_tx    <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= START;
`ifdef UART_TX_PARITY_EN
                        r_parity <= (^i_tx_data) ^ LP_ODD_BIT;
`endif
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LP_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= STOP;
`endif
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        if (r_stop_cnt == LP_LAST_STOP) begin
                            r_ready <= LP_CFG_OK;
                            r_state <= IDLE;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_uart_tx  = r_tx;
    assign o_tx_ready = r_ready;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed self-checking bench for uart_tx_core (DIV = 10)
module tb_uart_tx_core;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 5_000_000;
    localparam int DIV    = 10;
    localparam int ODD    = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PAR    = 1;
`else
    localparam int PAR    = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data, data2;
    logic       valid, valid2;
    logic       ready, tx, ready2, tx2;

    int n_checks = 0;
    int n_pass   = 0;

    logic cap_tx  [0:511];
    logic cap_rdy [0:511];
    logic cap_tx2 [0:511];
    logic cap_rdy2[0:511];

    always #5 clk = ~clk;

    uart_tx_core #(
        .P_CLK_FREQ(CLK_HZ), .P_BAUD(BAUD), .P_DATA_WIDTH(8), .P_STOP_BITS(1), .P_PARITY_ODD(ODD)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid),
        .o_tx_ready(ready), .o_uart_tx(tx)
    );

    uart_tx_core #(
        .P_CLK_FREQ(CLK_HZ), .P_BAUD(BAUD), .P_DATA_WIDTH(8), .P_STOP_BITS(2), .P_PARITY_ODD(ODD)
    ) dut2 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(data2), .i_tx_valid(valid2),
        .o_tx_ready(ready2), .o_uart_tx(tx2)
    );

    function automatic int frame_len(input int stops);
        return 1 + 8 + PAR + stops;
    endfunction

    // Expected line level for bit slot b of a frame carrying d
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PAR == 1 && b == 9) return (^d) ^ (ODD != 0);
        return 1'b1;
    endfunction

    // Record both DUTs' outputs on n consecutive falling edges
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_tx[i]   = tx;
            cap_rdy[i]  = ready;
            cap_tx2[i]  = tx2;
            cap_rdy2[i] = ready2;
            @(negedge clk);
        end
    endtask

    task automatic start_send(input logic [7:0] d);
        data  = d;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) $display("FAIL reset_line: got %b expected 1", tx); else n_pass++;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else n_pass++;
        n_checks++;
        if (tx2 !== 1'b1) $display("FAIL reset_line2: got %b expected 1", tx2); else n_pass++;
        rst = 1'b0; valid = 1'b0; valid2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) $display("FAIL release_ready: got %b expected 1", ready); else n_pass++;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL release_line: got %b expected 1", tx); else n_pass++;
        n_checks++;
        if (ready2 !== 1'b1) $display("FAIL release_ready2: got %b expected 1", ready2); else n_pass++;
    endtask

    task automatic test_basic();
        int  nb;
        logic ok, bad;
        nb = frame_len(1);
        start_send(8'h55);
        capture(nb * DIV + 1);
        for (int b = 0; b < nb; b++) begin
            ok = 1'b1; bad = 1'bx;
            for (int c = 0; c < DIV; c++)
                if (cap_tx[b*DIV+c] !== exp_bit(8'h55, b)) begin ok = 1'b0; bad = cap_tx[b*DIV+c]; end
            n_checks++;
            if (!ok) $display("FAIL basic_bit%0d: got %b expected %b", b, bad, exp_bit(8'h55, b));
            else n_pass++;
        end
        ok = 1'b1;
        for (int i = 0; i < nb * DIV; i++) if (cap_rdy[i] !== 1'b0) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL basic_ready_low: got 1 expected 0 for %0d cycles", nb * DIV); else n_pass++;
        n_checks++;
        if (cap_rdy[nb*DIV] !== 1'b1) $display("FAIL basic_ready_end: got %b expected 1", cap_rdy[nb*DIV]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   nb;
        logic ok, bad;
        nb = frame_len(1);
        data  = 8'hA3;
        valid = 1'b1;
        @(negedge clk);
        data = 8'h0F;
        fork
            capture(2 * nb * DIV + 2);
            begin
                repeat (nb * DIV + 1) @(negedge clk);
                valid = 1'b0;
            end
        join
        for (int b = 0; b < nb; b++) begin
            ok = 1'b1; bad = 1'bx;
            for (int c = 0; c < DIV; c++)
                if (cap_tx[b*DIV+c] !== exp_bit(8'hA3, b)) begin ok = 1'b0; bad = cap_tx[b*DIV+c]; end
            n_checks++;
            if (!ok) $display("FAIL b2b_a3_bit%0d: got %b expected %b", b, bad, exp_bit(8'hA3, b));
            else n_pass++;
        end
        n_checks++;
        if (cap_rdy[nb*DIV] !== 1'b1 || cap_tx[nb*DIV] !== 1'b1)
            $display("FAIL b2b_gap: ready=%b line=%b expected ready=1 line=1", cap_rdy[nb*DIV], cap_tx[nb*DIV]);
        else n_pass++;
        for (int b = 0; b < nb; b++) begin
            ok = 1'b1; bad = 1'bx;
            for (int c = 0; c < DIV; c++)
                if (cap_tx[nb*DIV+1+b*DIV+c] !== exp_bit(8'h0F, b)) begin ok = 1'b0; bad = cap_tx[nb*DIV+1+b*DIV+c]; end
            n_checks++;
            if (!ok) $display("FAIL b2b_0f_bit%0d: got %b expected %b", b, bad, exp_bit(8'h0F, b));
            else n_pass++;
        end
        n_checks++;
        if (cap_rdy[2*nb*DIV+1] !== 1'b1) $display("FAIL b2b_ready_end: got %b expected 1", cap_rdy[2*nb*DIV+1]);
        else n_pass++;
    endtask

    task automatic test_ignore_midframe();
        int   nb;
        logic ok, bad;
        nb = frame_len(1);
        data  = 8'h96;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        fork
            capture(nb * DIV + 21);
            begin
                repeat (35) @(negedge clk);
                data  = 8'h00;
                valid = 1'b1;
                @(negedge clk);
                valid = 1'b0;
            end
        join
        for (int b = 0; b < nb; b++) begin
            ok = 1'b1; bad = 1'bx;
            for (int c = 0; c < DIV; c++)
                if (cap_tx[b*DIV+c] !== exp_bit(8'h96, b)) begin ok = 1'b0; bad = cap_tx[b*DIV+c]; end
            n_checks++;
            if (!ok) $display("FAIL ignore_bit%0d: got %b expected %b", b, bad, exp_bit(8'h96, b));
            else n_pass++;
        end
        ok = 1'b1;
        for (int i = nb * DIV; i <= nb * DIV + 20; i++) if (cap_tx[i] !== 1'b1 || cap_rdy[i] !== 1'b1) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL ignore_no_queue: got line/ready low after frame expected both 1");
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int   nb;
        logic ok, bad;
        nb = frame_len(1);
        start_send(8'hF0);
        fork
            capture(61);
            begin
                repeat (34) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        n_checks++;
        if (cap_tx[34] !== 1'b0) $display("FAIL rstmid_pre: got %b expected 0", cap_tx[34]); else n_pass++;
        n_checks++;
        if (cap_tx[35] !== 1'b1) $display("FAIL rstmid_line: got %b expected 1", cap_tx[35]); else n_pass++;
        n_checks++;
        if (cap_rdy[35] !== 1'b0) $display("FAIL rstmid_ready_in_rst: got %b expected 0", cap_rdy[35]); else n_pass++;
        n_checks++;
        if (cap_rdy[36] !== 1'b1) $display("FAIL rstmid_ready_release: got %b expected 1", cap_rdy[36]); else n_pass++;
        ok = 1'b1;
        for (int i = 36; i <= 60; i++) if (cap_tx[i] !== 1'b1 || cap_rdy[i] !== 1'b1) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL rstmid_residual: got activity after release expected idle"); else n_pass++;
        start_send(8'h3C);
        capture(nb * DIV + 1);
        for (int b = 0; b < nb; b++) begin
            ok = 1'b1; bad = 1'bx;
            for (int c = 0; c < DIV; c++)
                if (cap_tx[b*DIV+c] !== exp_bit(8'h3C, b)) begin ok = 1'b0; bad = cap_tx[b*DIV+c]; end
            n_checks++;
            if (!ok) $display("FAIL rstmid_3c_bit%0d: got %b expected %b", b, bad, exp_bit(8'h3C, b));
            else n_pass++;
        end
        n_checks++;
        if (cap_rdy[nb*DIV] !== 1'b1) $display("FAIL rstmid_3c_ready: got %b expected 1", cap_rdy[nb*DIV]);
        else n_pass++;
    endtask

    task automatic test_two_stop();
        int   nb;
        logic ok, bad;
        nb = frame_len(2);
        data2  = 8'hFF;
        valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        capture(nb * DIV + 1);
        for (int b = 0; b < nb; b++) begin
            ok = 1'b1; bad = 1'bx;
            for (int c = 0; c < DIV; c++)
                if (cap_tx2[b*DIV+c] !== exp_bit(8'hFF, b)) begin ok = 1'b0; bad = cap_tx2[b*DIV+c]; end
            n_checks++;
            if (!ok) $display("FAIL stop2_bit%0d: got %b expected %b", b, bad, exp_bit(8'hFF, b));
            else n_pass++;
        end
        ok = 1'b1;
        for (int i = (9 + PAR) * DIV; i < (9 + PAR) * DIV + 20; i++) if (cap_tx2[i] !== 1'b1) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL stop2_high: got low during stop expected 20 high cycles"); else n_pass++;
        n_checks++;
        if (cap_rdy2[nb*DIV-1] !== 1'b0) $display("FAIL stop2_ready_early: got %b expected 0", cap_rdy2[nb*DIV-1]);
        else n_pass++;
        n_checks++;
        if (cap_rdy2[nb*DIV] !== 1'b1) $display("FAIL stop2_ready_end: got %b expected 1", cap_rdy2[nb*DIV]);
        else n_pass++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic ok, bad;
        logic exp_par;
        exp_par = (ODD == 0) ? 1'b1 : 1'b0;
        start_send(8'h07);
        capture(111);
        ok = 1'b1; bad = 1'bx;
        for (int c = 90; c < 100; c++) if (cap_tx[c] !== exp_par) begin ok = 1'b0; bad = cap_tx[c]; end
        n_checks++;
        if (!ok) $display("FAIL parity_bit: got %b expected %b", bad, exp_par); else n_pass++;
        n_checks++;
        if (cap_rdy[109] !== 1'b0 || cap_rdy[110] !== 1'b1)
            $display("FAIL parity_len: ready %b%b expected 01 at 110 cycles", cap_rdy[109], cap_rdy[110]);
        else n_pass++;
    endtask
`endif

    initial begin
        rst    = 1'b1;
        valid  = 1'b1;
        data   = 8'hAA;
        valid2 = 1'b1;
        data2  = 8'h00;
        test_reset();
        repeat (3) @(negedge clk);
        test_basic();
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_ignore_midframe();
        repeat (3) @(negedge clk);
        test_reset_midframe();
        repeat (3) @(negedge clk);
        test_two_stop();
`ifdef UART_TX_PARITY_EN
        repeat (3) @(negedge clk);
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
